// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam int NUM_REQ_DEF = 4;
    localparam int BYTE_W      = 8;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: searches upward from ptr+1, wrapping at N.
module uart_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        logic [IW-1:0] w_pos;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        w_pos = '0;
        for (int k = 1; k <= N; k++) begin
            w_pos = IW'((int'(ptr) + k) % N);
            if (!any && req[w_pos]) begin
                grant[w_pos] = 1'b1;
                idx          = w_pos;
                any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NUM_REQ requesters into a simple UART transmitter.
// Optional packet lock: define UART_TX_ARB_PKT_LOCK_EN to keep a requester granted until req_last.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic                         clock,
    input  logic                         arst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0]    req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [BYTE_W-1:0]            tx_value,
    output logic                         tx_value_write,
    input  logic                         tx_value_done,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy
);

    localparam int IDW = $clog2(NUM_REQ);

`ifdef UART_TX_ARB_PKT_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BYTE_W-1:0]   r_tx_value;
    logic [IDW-1:0]      r_rr_ptr;
    logic [IDW-1:0]      r_grant_id;
    logic                r_lock;
    logic [NUM_REQ-1:0]  w_lock_mask;
    logic [NUM_REQ-1:0]  w_eligible;
    logic [NUM_REQ-1:0]  w_grant;
    logic [IDW-1:0]      w_win_idx;
    logic                w_win_any;
    logic                w_accept;

    // The lock owner is always the last granted requester.
    always_comb begin
        w_lock_mask             = '0;
        w_lock_mask[r_grant_id] = 1'b1;
    end

    assign w_eligible = (LOCK_EN && r_lock) ? (req_valid & w_lock_mask) : req_valid;

    uart_rr_pick #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_rr_pick (
        .req   (w_eligible),
        .ptr   (r_rr_ptr),
        .grant (w_grant),
        .idx   (w_win_idx),
        .any   (w_win_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        req_ready   = '0;
        case (r_state)
            IDLE: begin
                if (w_win_any) begin
                    req_ready   = w_grant;
                    w_accept    = 1'b1;
                    w_state_nxt = WRITE;
                end
            end
            WRITE:     w_state_nxt = WAIT_DONE;
            WAIT_DONE: if (tx_value_done) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            r_state    <= IDLE;
            r_tx_value <= '0;
            r_rr_ptr   <= IDW'(NUM_REQ - 1);
            r_grant_id <= '0;
            r_lock     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_tx_value <= req_data[int'(w_win_idx)*BYTE_W +: BYTE_W];
                r_rr_ptr   <= w_win_idx;
                r_grant_id <= w_win_idx;
                r_lock     <= LOCK_EN && !req_last[w_win_idx];
            end
        end
    end

    assign tx_value       = r_tx_value;
    assign tx_value_write = (r_state == WRITE);
    assign busy           = (r_state != IDLE);
    assign grant_id       = r_grant_id;

endmodule
